score_display_ctrl: RTL

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_pkg.sv | 40 ++++
 rtl/bcd_digit_inc.sv | 28 ++
 rtl/score_display_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// score_pkg -- shared types and constants for the score display controller.
//   state_t     : update FSM state
//   bcd_t       : one BCD digit
//   DEF_*       : default geometry / digit count
//   pend_next() : next value of a 2-bit saturating pending-event counter
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UPDATE_A = 2'd1,
        ST_UPDATE_B = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int DEF_DIGITS  = 3;
    localparam int DEF_DIGIT_W = 16;
    localparam int DEF_DIGIT_H = 24;
    localparam int DEF_X_A     = 20;
    localparam int DEF_X_B     = 560;
    localparam int DEF_Y_ROW   = 20;

    localparam logic [1:0] PEND_MAX = 2'd3;

    // A consumed unit is removed first, a clear then drops everything older,
    // and an event arriving in the same cycle is always kept (up to saturation).
    function automatic logic [1:0] pend_next(input logic [1:0] cur,
                                             input logic       dec,
                                             input logic       clr,
                                             input logic       inc);
        logic [1:0] p;
        p = cur;
        if (dec && (p != 2'd0)) p = p - 2'd1;
        if (clr)                p = 2'd0;
        if (inc && (p != PEND_MAX)) p = p + 2'd1;
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// bcd_digit_inc -- add a carry-in to one BCD digit.
//   d    : input digit (0..9)
//   cin  : carry in (1 = add one)
//   q    : result digit
//   cout : carry out (digit wrapped from 9 to 0)
module bcd_digit_inc
    import score_pkg::*;
(
    input  bcd_t d,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (d >= 4'd9) begin
                q    = '0;
                cout = 1'b1;
            end else begin
                q = d + 4'd1;
            end
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl -- two-player BCD score keeper with tear-free display
// buffers and a registered pixel-to-glyph-slot lookup.
//
// Ports:
//   clk, reset (async, active-low)
//   i_animate           : end-of-frame pulse, starts a deferred update
//   i_inc_a / i_inc_b   : point events for player A / B
//   i_clr               : request to zero both scores
//   i_x / i_y           : current pixel position
//   o_num / o_pos       : digit value and slot index of the glyph under i_x/i_y
//   o_xoff / o_yoff     : top-left pixel of that glyph cell
//   o_valid             : pixel lies inside a score cell
//   o_busy              : update FSM is not idle
//
// Build option: define SCORE_SAT_EN to hold a score at all-9s instead of
// wrapping to all-0s.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int DIGITS  = DEF_DIGITS,
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int DIGIT_H = DEF_DIGIT_H,
    parameter int X_A     = DEF_X_A,
    parameter int X_B     = DEF_X_B,
    parameter int Y_ROW   = DEF_Y_ROW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_animate,
    input  logic       i_inc_a,
    input  logic       i_inc_b,
    input  logic       i_clr,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    output logic [5:0] o_num,
    output logic [5:0] o_pos,
    output logic [9:0] o_xoff,
    output logic [8:0] o_yoff,
    output logic       o_valid,
    output logic       o_busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    localparam int unsigned XA_U = X_A;
    localparam int unsigned XB_U = X_B;
    localparam int unsigned YR_U = Y_ROW;
    localparam int unsigned W_U  = DIGIT_W;
    localparam int unsigned H_U  = DIGIT_H;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    carry_q;
    logic [1:0]              pending_a, pending_b;
    logic [1:0]              pend_a_nx, pend_b_nx;
    logic                    clr_pend;
    bcd_t [DIGITS-1:0]       work_a, work_b;
    bcd_t [DIGITS-1:0]       disp_a, disp_b;

    logic                    upd_a, upd_b, last_digit, skip, go;
    logic                    dec_a, dec_b, start_cin;
    bcd_t                    inc_d, inc_q;
    logic                    inc_cin, inc_cout;

`ifdef SCORE_SAT_EN
    logic                    all_nines;
`endif

    // ------------------------------------------------------------------
    // Update datapath: a single digit incrementer walks LSD..MSD of the
    // player being updated, one digit per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        upd_a      = (state == ST_UPDATE_A);
        upd_b      = (state == ST_UPDATE_B);
        last_digit = (idx == LAST_IDX);
        go         = (state == ST_IDLE) && i_animate &&
                     ((pending_a != 2'd0) || (pending_b != 2'd0) || clr_pend);
        // Nothing to do for this player: spend one cycle and move on.
        skip       = (idx == '0) && (upd_a ? (pending_a == 2'd0) : (pending_b == 2'd0));
        inc_d      = upd_b ? work_b[idx] : work_a[idx];

`ifdef SCORE_SAT_EN
        all_nines = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((upd_b ? work_b[i] : work_a[i]) != 4'd9) all_nines = 1'b0;
        end
        start_cin = ~all_nines;
`else
        start_cin = 1'b1;
`endif
        inc_cin = (idx == '0) ? start_cin : carry_q;

        // A pending unit is consumed when its MSD has been processed.
        dec_a     = upd_a && last_digit && !skip;
        dec_b     = upd_b && last_digit && !skip;
        pend_a_nx = pend_next(pending_a, dec_a, i_clr, i_inc_a);
        pend_b_nx = pend_next(pending_b, dec_b, i_clr, i_inc_b);
    end

    bcd_digit_inc u_inc (
        .d    (inc_d),
        .cin  (inc_cin),
        .q    (inc_q),
        .cout (inc_cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            pending_a <= 2'd0;
            pending_b <= 2'd0;
            clr_pend  <= 1'b0;
            work_a    <= '0;
            work_b    <= '0;
            disp_a    <= '0;
            disp_b    <= '0;
        end else begin
            pending_a <= pend_a_nx;
            pending_b <= pend_b_nx;

            if (i_clr)   clr_pend <= 1'b1;
            else if (go) clr_pend <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_UPDATE_A;
                        idx   <= '0;
                        if (clr_pend) begin
                            work_a <= '0;
                            work_b <= '0;
                        end
                    end
                end
                ST_UPDATE_A: begin
                    if (skip) begin
                        state <= ST_UPDATE_B;
                        idx   <= '0;
                    end else begin
                        work_a[idx] <= inc_q;
                        carry_q     <= inc_cout;
                        if (last_digit) begin
                            idx <= '0;
                            if (pend_a_nx == 2'd0) state <= ST_UPDATE_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_UPDATE_B: begin
                    if (skip) begin
                        state <= ST_COMMIT;
                        idx   <= '0;
                    end else begin
                        work_b[idx] <= inc_q;
                        carry_q     <= inc_cout;
                        if (last_digit) begin
                            idx <= '0;
                            if (pend_b_nx == 2'd0) state <= ST_COMMIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    disp_a <= work_a;
                    disp_b <= work_b;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Pixel -> glyph slot lookup (registered)
    // ------------------------------------------------------------------
    logic [31:0] x_u, y_u;
    logic        in_row, hit_c;
    logic [5:0]  num_c, pos_c;
    logic [9:0]  xoff_c;
    logic [8:0]  yoff_c;

    always_comb begin
        x_u    = 32'(i_x);
        y_u    = 32'(i_y);
        in_row = (y_u >= YR_U) && (y_u < YR_U + H_U);
        hit_c  = 1'b0;
        num_c  = '0;
        pos_c  = '0;
        xoff_c = '0;
        yoff_c = '0;
        for (int unsigned p = 0; p < DIGITS; p++) begin
            if (in_row && (x_u >= XA_U + p * W_U) && (x_u < XA_U + (p + 1) * W_U)) begin
                hit_c  = 1'b1;
                num_c  = {2'b00, disp_a[DIGITS - 1 - p]};
                pos_c  = 6'(p);
                xoff_c = 10'(XA_U + p * W_U);
                yoff_c = 9'(YR_U);
            end
            if (in_row && (x_u >= XB_U + p * W_U) && (x_u < XB_U + (p + 1) * W_U)) begin
                hit_c  = 1'b1;
                num_c  = {2'b00, disp_b[DIGITS - 1 - p]};
                pos_c  = 6'(DIGITS + p);
                xoff_c = 10'(XB_U + p * W_U);
                yoff_c = 9'(YR_U);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid <= 1'b0;
            o_num   <= '0;
            o_pos   <= '0;
            o_xoff  <= '0;
            o_yoff  <= '0;
        end else begin
            o_valid <= hit_c;
            o_num   <= num_c;
            o_pos   <= pos_c;
            o_xoff  <= xoff_c;
            o_yoff  <= yoff_c;
        end
    end

endmodule
